uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the SOC's `RXD` line, the receiving counterpart of the SOC's UART transmitter on `TXD`. It deserialises 8N1 frames (optionally 8E1), presents each byte through a valid/ready holding register to the CPU bus glue, and flags framing, parity and overrun errors. It sits between the board `RXD` pin and the SOC's memory-mapped UART status/data register.

## Interface

Parameters:
- `CLK_FREQ_HZ`, default 12_000_000: frequency of `CLK`.
- `BAUD_RATE`, default 115_200: line rate.
- `CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE` is derived (integer division). Elaboration fails if it is below 4.

Ports:
- `CLK` input, 1 bit: system clock. Every flop is rising-edge.
- `RESET` input, 1 bit: synchronous, active-high.
- `RXD` input, 1 bit: asynchronous serial line; idles high.
- `DATA` output, 8 bits: received byte. Valid while `VALID` is high.
- `VALID` output, 1 bit: the holding register holds an unconsumed byte.
- `READY` input, 1 bit: the consumer accepts `DATA` on any cycle where `VALID && READY`.
- `FRAME_ERR` output, 1 bit: one-cycle pulse when the stop bit is sampled low.
- `PARITY_ERR` output, 1 bit: one-cycle pulse on a parity mismatch. Tied to 0 unless `UART_RX_PARITY_EN` is defined.
- `OVERRUN` output, 1 bit: one-cycle pulse when a good byte completes while `VALID` is still high.

## Operation

- **Reset state:**
  - `RXD` passes through a 2-flop synchroniser, giving `rxd_s`. Both flops reset to 1.
  - On reset: state=IDLE, `DATA`=8'h00, `VALID`=0, `FRAME_ERR`=0, `PARITY_ERR`=0, `OVERRUN`=0, bit counter=0, clock counter=0.
- **IDLE:** on `rxd_s`==0, load the clock counter with `CLKS_PER_BIT/2 - 1`, then go to START.
- **START:** count down to 0, then sample `rxd_s`.
  - If 0: go to DATA with bit index 0 and the counter reloaded to `CLKS_PER_BIT - 1`.
  - If 1 (false start/glitch): go to IDLE with no outputs.
- **DATA:** at each counter expiry, sample `rxd_s` into shift-register bit [index], LSB first. After bit 7, go to PARITY if enabled, else to STOP.
- **PARITY** (only with the macro): sample 1 bit. Expected value is the even parity, ^shift.
- **STOP:** at counter expiry (mid-stop-bit), sample `rxd_s`, then return to IDLE the same cycle.
  - 0: pulse `FRAME_ERR`. Byte discarded, `VALID` unchanged.
  - 1 with parity mismatch: pulse `PARITY_ERR`. Byte discarded.
  - 1 and good, `VALID`==0 (or being consumed this same cycle): load `DATA`, set `VALID`.
  - 1 and good, `VALID`==1 and not consumed this cycle: pulse `OVERRUN`. New byte dropped, old `DATA` kept.
- **Handshake:** `VALID` clears the cycle after `VALID && READY`. A simultaneous consume and store leaves `VALID`=1 with the new byte.
- **Back-to-back frames:** returning to IDLE at mid-stop lets a start bit that immediately follows the stop bit be detected without loss.
- **Reset mid-frame:** the partial byte is discarded and the block returns to IDLE. A frame in progress at reset release is ignored until the line is seen low again from IDLE. The receiver may therefore resynchronise on a data bit; this is accepted.

## Timing

- Synchroniser latency: 2 cycles from a `RXD` edge to `rxd_s`.
- Sample points: bit n (start=0, data=1..8, stop=9, or 10 with parity) is sampled at about `n*CLKS_PER_BIT + CLKS_PER_BIT/2` cycles after the `rxd_s` falling edge.
- Output latency: `VALID`, `FRAME_ERR`, `PARITY_ERR` and `OVERRUN` are registered. They assert 1 cycle after the stop sample.
- Error pulses are exactly 1 cycle wide.
- `DATA` is stable for as long as `VALID` is high.

## Configuration

- `UART_RX_PARITY_EN` defined: the frame is 8E1, the PARITY state exists, and `PARITY_ERR` is live.
- `UART_RX_PARITY_EN` not defined: the frame is 8N1, there is no PARITY state, and `PARITY_ERR` is constant 0.
- The port list is identical in both builds.

## Structure

- **Package `uart_pkg`:**
  - state enum: IDLE, START, DATA, PARITY, STOP;
  - function `clks_per_bit(freq, baud)`;
  - constant `UART_DATA_BITS = 8`.
  - The package is shared with the SOC's transmitter.
- **Sub-module `uart_rx_sync`:** the 2-flop reset-to-1 synchroniser, reused for other asynchronous inputs.

## Test plan

Bench parameters: `CLK_FREQ_HZ`=1_000_000, `BAUD_RATE`=100_000, giving 10 clocks per bit.

- **Single byte:** `READY`=1, send 8'hA5 → `VALID` pulses one cycle with `DATA`=8'hA5, about 97 cycles after the start edge. No error pulses.
- **Glitch:** `RXD` low for 3 cycles, then high → no `VALID` and no errors. The block is in IDLE and then receives a subsequent 8'h3C correctly.
- **Framing error:** send 8'h55 with the stop bit held low → `FRAME_ERR` pulses once, `VALID` stays 0.
- **Overrun:** `READY`=0, send 8'h11 then 8'h22 back-to-back → `DATA`=8'h11 with `VALID`=1, `OVERRUN` pulses at the second stop bit. After `READY`=1 for one cycle, `VALID`=0.
- **Reset mid-frame:** `RESET` at data bit 4 of 8'hFF, then a full frame of 8'h81 → only `DATA`=8'h81 is reported.
- **Parity** (build with `UART_RX_PARITY_EN`): send 8'h07 with parity bit 1 → `VALID`, `DATA`=8'h07. Send the same byte with parity bit 0 → `PARITY_ERR` pulses, no `VALID`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, bit-period helper and frame width.
// Used by both the receiver and the SOC transmitter.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned freq, input int unsigned baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous inputs; both stages reset to 1 so an
// idle-high line does not produce a spurious falling edge after reset.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready holding register and error pulses.
// Define UART_RX_PARITY_EN for 8E1 framing with a live PARITY_ERR output.
module uart_rx #(
  parameter int unsigned CLK_FREQ_HZ = 12_000_000,
  parameter int unsigned BAUD_RATE   = 115_200
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RXD,
  output logic [7:0] DATA,
  output logic       VALID,
  input  logic       READY,
  output logic       FRAME_ERR,
  output logic       PARITY_ERR,
  output logic       OVERRUN
);

  import uart_pkg::*;

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD  = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_baud_check
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end

  logic                      rxd_s;
  uart_state_e               state;
  logic [CW-1:0]             cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      tick;

  assign tick = (cnt == '0);

  uart_rx_sync u_sync (
    .clk   (CLK),
    .reset (RESET),
    .d     (RXD),
    .q     (rxd_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad;
`else
  assign PARITY_ERR = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      DATA      <= '0;
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      PARITY_ERR <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      PARITY_ERR <= 1'b0;
`endif
      if (VALID && READY)
        VALID <= 1'b0;

      case (state)
        IDLE: begin
          if (!rxd_s) begin
            cnt   <= HALF_LOAD;
            state <= START;
          end
        end
        START: begin
          if (!tick) begin
            cnt <= cnt - 1'b1;
          end else if (!rxd_s) begin
            state   <= uart_pkg::DATA;
            bit_idx <= '0;
            cnt     <= FULL_LOAD;
          end else begin
            state <= IDLE;
          end
        end
        uart_pkg::DATA: begin
          if (!tick) begin
            cnt <= cnt - 1'b1;
          end else begin
            shift[bit_idx] <= rxd_s;
            cnt            <= FULL_LOAD;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (!tick) begin
            cnt <= cnt - 1'b1;
          end else begin
            par_bad <= (rxd_s != ^shift);
            cnt     <= FULL_LOAD;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (!tick) begin
            cnt <= cnt - 1'b1;
          end else begin
            // Leaving at mid-stop lets an immediately following start bit be caught.
            state <= IDLE;
            if (!rxd_s) begin
              FRAME_ERR <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad) begin
              PARITY_ERR <= 1'b1;
`endif
            end else if (!VALID || READY) begin
              DATA  <= shift;
              VALID <= 1'b1;
            end else begin
              OVERRUN <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 10 clocks per bit; define UART_RX_PARITY_EN
// to build the 8E1 variant and its parity scenario.
module tb_uart_rx;

  localparam int CPB = 10;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       RXD;
  logic       READY;
  logic [7:0] DATA;
  logic       VALID;
  logic       FRAME_ERR;
  logic       PARITY_ERR;
  logic       OVERRUN;

  uart_rx #(
    .CLK_FREQ_HZ (1_000_000),
    .BAUD_RATE   (100_000)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .RXD        (RXD),
    .DATA       (DATA),
    .VALID      (VALID),
    .READY      (READY),
    .FRAME_ERR  (FRAME_ERR),
    .PARITY_ERR (PARITY_ERR),
    .OVERRUN    (OVERRUN)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  int   valid_cyc      = 0;
  int   frame_cyc      = 0;
  int   par_cyc        = 0;
  int   ovr_cyc        = 0;
  int   valid_rise_cyc = 0;
  logic valid_d        = 1'b0;

  int v0, f0, p0, o0, st;

  always @(posedge CLK) cyc++;

  // Monitor: pulse-width accounting and scoreboard pop on each accepted byte.
  always @(negedge CLK) begin
    if (VALID)      valid_cyc++;
    if (FRAME_ERR)  frame_cyc++;
    if (PARITY_ERR) par_cyc++;
    if (OVERRUN)    ovr_cyc++;
    if (VALID && !valid_d) valid_rise_cyc = cyc;
    valid_d = VALID;
    if (VALID && READY && !RESET) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_unexpected: got DATA=%02h, required no output", DATA);
      end else begin
        exp_b = exp_q.pop_front();
        if (DATA !== exp_b) begin
          n_fail++;
          $display("FAIL scoreboard_data: got DATA=%02h, required %02h", DATA, exp_b);
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    RXD = b;
    repeat (CPB) @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    RXD = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_val);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^b);
`endif
    drive_bit(stop_val);
  endtask

  task automatic snap();
    v0 = valid_cyc;
    f0 = frame_cyc;
    p0 = par_cyc;
    o0 = ovr_cyc;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    RXD   = 1'b1;
    READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++; if (DATA !== 8'h00)     begin n_fail++; $display("FAIL reset_data: got %02h, required 00", DATA); end
    n_checks++; if (VALID !== 1'b0)     begin n_fail++; $display("FAIL reset_valid: got %b, required 0", VALID); end
    n_checks++; if (FRAME_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b, required 0", FRAME_ERR); end
    n_checks++; if (PARITY_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b, required 0", PARITY_ERR); end
    n_checks++; if (OVERRUN !== 1'b0)   begin n_fail++; $display("FAIL reset_overrun: got %b, required 0", OVERRUN); end
    RESET = 1'b0;
    idle(5);
  endtask

  task automatic test_single_byte();
    snap();
    exp_q.push_back(8'hA5);
    st = cyc;
    send_frame(8'hA5, 1'b1);
    idle(10);
    n_checks++; if (valid_cyc - v0 != 1) begin n_fail++; $display("FAIL single_valid_width: got %0d cycles, required 1", valid_cyc - v0); end
    n_checks++; if (valid_rise_cyc - st < 95 || valid_rise_cyc - st > 100) begin
      n_fail++; $display("FAIL single_latency: got %0d cycles, required 95..100", valid_rise_cyc - st);
    end
    n_checks++; if (frame_cyc + par_cyc + ovr_cyc != f0 + p0 + o0) begin
      n_fail++; $display("FAIL single_errors: got %0d error cycles, required 0", frame_cyc + par_cyc + ovr_cyc - f0 - p0 - o0);
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_received: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_glitch();
    snap();
    RXD = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    idle(30);
    n_checks++; if (valid_cyc != v0) begin n_fail++; $display("FAIL glitch_valid: got %0d valid cycles, required 0", valid_cyc - v0); end
    n_checks++; if (frame_cyc + par_cyc + ovr_cyc != f0 + p0 + o0) begin
      n_fail++; $display("FAIL glitch_errors: got %0d error cycles, required 0", frame_cyc + par_cyc + ovr_cyc - f0 - p0 - o0);
    end
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    idle(10);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL glitch_followup: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_frame_err();
    snap();
    send_frame(8'h55, 1'b0);
    idle(20);
    n_checks++; if (frame_cyc - f0 != 1) begin n_fail++; $display("FAIL frame_err_pulse: got %0d cycles, required 1", frame_cyc - f0); end
    n_checks++; if (valid_cyc != v0) begin n_fail++; $display("FAIL frame_err_valid: got %0d valid cycles, required 0", valid_cyc - v0); end
    n_checks++; if (ovr_cyc + par_cyc != o0 + p0) begin n_fail++; $display("FAIL frame_err_other: got %0d cycles, required 0", ovr_cyc + par_cyc - o0 - p0); end
  endtask

  task automatic test_overrun();
    snap();
    READY = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(10);
    n_checks++; if (VALID !== 1'b1)  begin n_fail++; $display("FAIL overrun_valid: got %b, required 1", VALID); end
    n_checks++; if (DATA !== 8'h11)  begin n_fail++; $display("FAIL overrun_data: got %02h, required 11", DATA); end
    n_checks++; if (ovr_cyc - o0 != 1) begin n_fail++; $display("FAIL overrun_pulse: got %0d cycles, required 1", ovr_cyc - o0); end
    n_checks++; if (frame_cyc != f0) begin n_fail++; $display("FAIL overrun_frame: got %0d cycles, required 0", frame_cyc - f0); end
    READY = 1'b1;
    @(posedge CLK);
    #1;
    READY = 1'b0;
    n_checks++; if (VALID !== 1'b0)  begin n_fail++; $display("FAIL overrun_consume: got VALID=%b, required 0", VALID); end
    READY = 1'b1;
    idle(5);
  endtask

  task automatic test_reset_mid();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    RXD = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    idle(4 + 3 * CPB + 2 * CPB);
    snap();
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    idle(10);
    n_checks++; if (valid_cyc - v0 != 1) begin n_fail++; $display("FAIL reset_mid_valid: got %0d cycles, required 1", valid_cyc - v0); end
    n_checks++; if (frame_cyc + par_cyc + ovr_cyc != f0 + p0 + o0) begin
      n_fail++; $display("FAIL reset_mid_errors: got %0d error cycles, required 0", frame_cyc + par_cyc + ovr_cyc - f0 - p0 - o0);
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL reset_mid_received: got %0d pending, required 0", exp_q.size()); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_par(input logic [7:0] b, input logic pbit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(pbit);
    drive_bit(1'b1);
  endtask

  task automatic test_parity();
    snap();
    exp_q.push_back(8'h07);
    send_par(8'h07, 1'b1);
    idle(10);
    n_checks++; if (valid_cyc - v0 != 1) begin n_fail++; $display("FAIL parity_good_valid: got %0d cycles, required 1", valid_cyc - v0); end
    n_checks++; if (par_cyc != p0) begin n_fail++; $display("FAIL parity_good_err: got %0d cycles, required 0", par_cyc - p0); end
    snap();
    send_par(8'h07, 1'b0);
    idle(10);
    n_checks++; if (par_cyc - p0 != 1) begin n_fail++; $display("FAIL parity_bad_pulse: got %0d cycles, required 1", par_cyc - p0); end
    n_checks++; if (valid_cyc != v0) begin n_fail++; $display("FAIL parity_bad_valid: got %0d cycles, required 0", valid_cyc - v0); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_scoreboard: got %0d pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
